// File: rtl/cache_nway_wb_pkg.sv
// Shared definitions for the N-way write-back data cache.
//   state_e    : controller states (idle/lookup, write-back, allocate/refill)
//   BLOCK_W    : memory block width (4 words)
//   WORD_W     : processor word width
//   MEM_ADDR_W : memory-side block address width
//   clog2      : ceiling log2 helper for elaboration-time widths
package cache_pkg;

  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MEM_ADDR_W  = 28;
  localparam int unsigned PROC_ADDR_W = 30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_nway_wb_lru_set.sv
// True-LRU rank vector for one cache set.
//   clk_i, rst_ni : clock, asynchronous active-low reset (rank[w] = w)
//   touch_i       : mark touch_way_i as most recently used this cycle
//   touch_way_i   : way being touched
//   victim_o      : way currently holding the highest rank (least recent)
// Ranks always form a permutation of 0..NUM_WAYS-1. Direct-mapped
// configurations keep no state and always name way 0.
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  localparam int unsigned WAY_W   = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             touch_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [WAY_W-1:0] victim_o
);

  if (NUM_WAYS > 1) begin : g_rank
    logic [WAY_W-1:0] rank_q [NUM_WAYS];
    logic [WAY_W-1:0] touch_rank;

    assign touch_rank = rank_q[touch_way_i];

    // Ways more recent than the touched one age by one; the touched way
    // becomes rank 0. Older ways keep their rank, so the set stays a permutation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          rank_q[WAY_W'(w)] <= WAY_W'(w);
        end
      end else if (touch_i) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          if (touch_way_i == WAY_W'(w)) begin
            rank_q[WAY_W'(w)] <= '0;
          end else if (rank_q[WAY_W'(w)] < touch_rank) begin
            rank_q[WAY_W'(w)] <= rank_q[WAY_W'(w)] + WAY_W'(1);
          end
        end
      end
    end

    always_comb begin
      victim_o = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (rank_q[WAY_W'(w)] == WAY_W'(NUM_WAYS - 1)) victim_o = WAY_W'(w);
      end
    end
  end else begin : g_direct
    logic unused_in;
    assign unused_in = clk_i ^ rst_ni ^ touch_i ^ touch_way_i[0];
    assign victim_o  = '0;
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative, write-back, write-allocate data cache.
//   clk, proc_reset_n        : clock, asynchronous active-low reset
//   proc_read/proc_write     : level requests held until proc_stall=0 (read wins)
//   proc_addr/proc_wdata     : word address {tag,set,offset}, write data
//   proc_stall/proc_rdata    : completion handshake, read data on read hits
//   mem_read/mem_write       : block refill / write-back requests
//   mem_addr/mem_wdata       : block address, write-back block (word 0 in [31:0])
//   mem_rdata/mem_ready      : refill block, one-cycle completion pulse
//   stat_hits/stat_misses    : saturating hit/miss counters
// Hits complete combinationally in IDLE. A miss stalls, optionally writes
// back a dirty victim, refills, then re-runs the lookup as a hit.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   proc_reset_n,
  input  logic                   proc_read,
  input  logic                   proc_write,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic                   proc_stall,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0]     mem_wdata,
  input  logic [BLOCK_W-1:0]     mem_rdata,
  input  logic                   mem_ready,
  output logic [CNT_W-1:0]       stat_hits,
  output logic [CNT_W-1:0]       stat_misses
);

  localparam int unsigned SET_W = clog2(NUM_SETS);
  localparam int unsigned TAG_W = MEM_ADDR_W - SET_W;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;

  logic [TAG_W-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic               valid_q [NUM_SETS][NUM_WAYS];
  logic               dirty_q [NUM_SETS][NUM_WAYS];

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [WORD_W-1:0] rdata_q;
  logic [CNT_W-1:0]  hits_q, misses_q;

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag_in;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [BLOCK_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  pick_way;
  logic [WAY_W-1:0]  lru_victim [NUM_SETS];

  logic              lru_touch;
  logic [WAY_W-1:0]  lru_way;
  logic              rd_hit, wr_hit, hit_done, miss_evt, wb_done, fill;

  assign set_idx  = proc_addr[2 +: SET_W];
  assign tag_in   = proc_addr[PROC_ADDR_W-1 -: TAG_W];
  assign req      = (proc_read | proc_write) & proc_reset_n;
  assign hit_line = data_q[set_idx][hit_way];
  assign hit_word = hit_line[{proc_addr[1:0], 5'b0} +: WORD_W];

  // Parallel tag compare; lowest matching way wins (only one can match).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[set_idx][WAY_W'(w)] && (tag_q[set_idx][WAY_W'(w)] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found && !valid_q[set_idx][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign pick_way = inv_found ? inv_way : lru_victim[set_idx];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
    cache_lru_set #(
      .NUM_WAYS(NUM_WAYS)
    ) u_lru (
      .clk_i      (clk),
      .rst_ni     (proc_reset_n),
      .touch_i    (lru_touch && (set_idx == SET_W'(s))),
      .touch_way_i(lru_way),
      .victim_o   (lru_victim[s])
    );
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lru_touch  = 1'b0;
    lru_way    = '0;
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    hit_done   = 1'b0;
    miss_evt   = 1'b0;
    wb_done    = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            lru_touch = 1'b1;
            lru_way   = hit_way;
            hit_done  = 1'b1;
            rd_hit    = proc_read;
            wr_hit    = ~proc_read;
          end else begin
            proc_stall = 1'b1;
            miss_evt   = 1'b1;
            victim_d   = pick_way;
            // An invalid victim is never dirty, so only a full set can need a write-back.
            state_d    = (!inv_found && dirty_q[set_idx][pick_way]) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[set_idx][victim_q], set_idx};
        mem_wdata  = data_q[set_idx][victim_q];
        if (mem_ready) begin
          wb_done = 1'b1;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[PROC_ADDR_W-1:2];
        if (mem_ready) begin
          fill      = 1'b1;
          lru_touch = 1'b1;
          lru_way   = victim_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign proc_rdata  = rd_hit ? hit_word : rdata_q;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      rdata_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (rd_hit) rdata_q <= hit_word;
      if (hit_done && (hits_q != '1)) hits_q <= hits_q + CNT_W'(1);
      if (miss_evt && (misses_q != '1)) misses_q <= misses_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
    end else begin
      if (wr_hit) dirty_q[set_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[set_idx][victim_q] <= 1'b0;
      if (fill) begin
        valid_q[set_idx][victim_q] <= 1'b1;
        dirty_q[set_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[set_idx][hit_way][{proc_addr[1:0], 5'b0} +: WORD_W] <= proc_wdata;
    if (fill) begin
      data_q[set_idx][victim_q] <= mem_rdata;
      tag_q[set_idx][victim_q]  <= tag_in;
    end
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Scoreboard bench for cache_nway_wb. A recency-ordered per-set model
// predicts completions and memory traffic; a monitor and a memory
// responder check the DUT against those predictions independently.
module tb_cache_nway_wb;

  localparam int unsigned NW   = 2;
  localparam int unsigned NS   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned NBLK = 16;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [CW-1:0] stat_hits, stat_misses;

  cache_nway_wb #(
    .NUM_WAYS(NW),
    .NUM_SETS(NS),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .proc_reset_n(proc_reset_n),
    .proc_read   (proc_read),
    .proc_write  (proc_write),
    .proc_addr   (proc_addr),
    .proc_wdata  (proc_wdata),
    .proc_stall  (proc_stall),
    .proc_rdata  (proc_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [27:0] blk; logic dirty; } line_t;
  typedef struct packed { logic is_rd; logic [31:0] rdata; logic [CW-1:0] hits; logic [CW-1:0] misses; } exp_t;
  typedef struct packed { logic is_wr; logic [27:0] addr; logic [127:0] data; } memop_t;

  line_t        lines [NS][$];   // front = most recently used
  logic [31:0]  view  [NBLK*4];  // processor-visible contents
  logic [127:0] mem   [NBLK];    // backing memory
  int unsigned  hits_cnt, miss_cnt;
  exp_t         exp_q[$];
  memop_t       memop_q[$];
  logic         hold_mem = 1'b0;
  logic         directed = 1'b0;

  function automatic logic [CW-1:0] sat(input int unsigned v);
    if (v >= (2**CW) - 1) return '1;
    return CW'(v);
  endfunction

  function automatic logic [127:0] block_view(input int unsigned blk);
    return {view[blk*4+3], view[blk*4+2], view[blk*4+1], view[blk*4]};
  endfunction

  // Reset discards cached (including dirty) data: the visible view falls back to memory.
  function automatic void model_reset();
    for (int unsigned s = 0; s < NS; s++) lines[s].delete();
    for (int unsigned b = 0; b < NBLK; b++)
      for (int unsigned k = 0; k < 4; k++) view[b*4+k] = mem[b][k*32 +: 32];
    hits_cnt = 0;
    miss_cnt = 0;
  endfunction

  function automatic void model_access(input logic rd, input logic [29:0] addr, input logic [31:0] wd);
    int unsigned blk;
    int unsigned s;
    int          idx;
    line_t       ln;
    exp_t        e;
    memop_t      m;
    blk = int'(addr[29:2]);
    s   = blk % NS;
    idx = -1;
    for (int i = 0; i < lines[s].size(); i++) if (lines[s][i].blk == 28'(blk)) idx = i;
    if (idx < 0) begin
      miss_cnt++;
      if (lines[s].size() == NW) begin
        ln = lines[s].pop_back();
        if (ln.dirty) begin
          m.is_wr = 1'b1; m.addr = ln.blk; m.data = block_view(int'(ln.blk));
          memop_q.push_back(m);
        end
      end
      m.is_wr = 1'b0; m.addr = 28'(blk); m.data = '0;
      memop_q.push_back(m);
      ln.blk = 28'(blk); ln.dirty = 1'b0;
    end else begin
      ln = lines[s][idx];
      lines[s].delete(idx);
    end
    e.is_rd  = rd;
    e.rdata  = view[blk*4 + addr[1:0]];
    e.hits   = sat(hits_cnt);
    e.misses = sat(miss_cnt);
    exp_q.push_back(e);
    hits_cnt++;
    if (!rd) begin
      view[blk*4 + addr[1:0]] = wd;
      ln.dirty = 1'b1;
    end
    lines[s].push_front(ln);
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wd);
    int unsigned n;
    n = 0;
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
    model_access(rd, addr, wd);
    do begin
      @(negedge clk);
      n++;
    end while (proc_stall && n < 200);
    check("req_completes_in_bound", proc_stall, 1'b0);
    if (proc_stall) finish_run();
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic idle_cycle();
    proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = 30'($urandom);
    @(negedge clk);
    check("idle_no_stall", proc_stall, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- completion monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (proc_reset_n && (proc_read || proc_write) && !proc_stall) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_completion: got completion at addr 0x%0h expected none", proc_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_rd) check("proc_rdata", proc_rdata, mon_e.rdata);
        check("stat_hits", stat_hits, mon_e.hits);
        check("stat_misses", stat_misses, mon_e.misses);
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    memop_t      m;
    logic        c_rd, c_wr;
    logic [27:0] c_addr;
    logic [127:0] c_wd;
    int unsigned d, bad;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (hold_mem || !proc_reset_n || !(mem_read || mem_write)) continue;
      c_rd = mem_read; c_wr = mem_write; c_addr = mem_addr; c_wd = mem_wdata;
      check("mem_rd_wr_exclusive", c_rd & c_wr, 1'b0);
      if (memop_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_mem_op: got wr=%0b addr 0x%0h expected none", c_wr, c_addr);
      end else begin
        m = memop_q.pop_front();
        check("mem_op_is_write", c_wr, m.is_wr);
        check("mem_addr", c_addr, m.addr);
        if (m.is_wr) check("mem_wdata", c_wd, m.data);
      end
      d   = directed ? 7 : $urandom_range(0, 7);
      bad = 0;
      repeat (d) begin
        @(negedge clk);
        if (mem_read !== c_rd || mem_write !== c_wr || mem_addr !== c_addr ||
            mem_wdata !== c_wd || proc_stall !== 1'b1) bad++;
      end
      check("mem_req_held_stable", bad, 0);
      if (c_wr) mem[c_addr[3:0]] = c_wd;
      mem_rdata = mem[c_addr[3:0]];
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 128'($urandom);
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int unsigned r, n;
    logic [27:0] blk;
    logic [1:0]  off;
    proc_reset_n = 1'b0;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    for (int unsigned b = 0; b < NBLK; b++) mem[b] = {$urandom, $urandom, $urandom, $urandom};
    mem[4][31:0] = 32'h1111_1111;
    model_reset();

    #3;
    check("rst_proc_stall", proc_stall, 1'b0);
    check("rst_proc_rdata", proc_rdata, 32'h0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_stat_hits", stat_hits, '0);
    check("rst_stat_misses", stat_misses, '0);
    repeat (2) @(posedge clk);
    #1 proc_reset_n = 1'b1;

    // Cold miss, write hit, conflict evictions in set 0 with slow memory.
    directed = 1'b1;
    do_req(1'b1, 1'b0, 30'h10, 32'h0);
    do_req(1'b0, 1'b1, 30'h10, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 30'h10, 32'h0);
    do_req(1'b1, 1'b0, 30'h20, 32'h0);
    do_req(1'b1, 1'b0, 30'h10, 32'h0);
    do_req(1'b1, 1'b0, 30'h30, 32'h0);
    do_req(1'b1, 1'b0, 30'h20, 32'h0);
    directed = 1'b0;

    // Random mix; both-high requests are reads.
    repeat (400) begin
      r   = $urandom_range(0, 4);
      blk = 28'($urandom_range(0, NBLK - 1));
      off = 2'($urandom);
      case (r)
        0, 1: do_req(1'b1, 1'b0, {blk, off}, 32'h0);
        2:    do_req(1'b0, 1'b1, {blk, off}, $urandom);
        3:    do_req(1'b1, 1'b1, {blk, off}, $urandom);
        default: idle_cycle();
      endcase
    end

    // Clean reset pulse: dirty data is dropped.
    proc_reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1 proc_reset_n = 1'b1;

    // Reset asserted while a refill is outstanding.
    hold_mem  = 1'b1;
    proc_read = 1'b1;
    proc_addr = 30'h10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_read && n < 10);
    check("alloc_mem_read_seen", mem_read, 1'b1);
    check("alloc_mem_addr", mem_addr, 28'h4);
    check("alloc_no_mem_write", mem_write, 1'b0);
    #2 proc_reset_n = 1'b0;
    #1;
    check("async_rst_mem_read", mem_read, 1'b0);
    check("async_rst_mem_write", mem_write, 1'b0);
    check("async_rst_proc_stall", proc_stall, 1'b0);
    proc_read = 1'b0;
    @(posedge clk); #1 proc_reset_n = 1'b1;
    hold_mem = 1'b0;
    model_reset();
    do_req(1'b1, 1'b0, 30'h10, 32'h0);
    do_req(1'b0, 1'b1, 30'h11, 32'h1234_5678);
    do_req(1'b1, 1'b0, 30'h11, 32'h0);

    repeat (3) idle_cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    check("memops_drained", memop_q.size(), 0);
    finish_run();
  end

endmodule
